// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE row feeder: FSM encoding, default pipeline
// latency and the lane counter width helper.
package pe_feeder_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        W_WAIT  = 2'd1,
        W_APPLY = 2'd2
    } feeder_state_t;

    // Row multiply register plus the partial-product register.
    localparam int DEFAULT_PIPE_LAT = 2;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that delays a valid bit by DEPTH cycles and reports whether
// any stage is still carrying a pulse.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic any_busy
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q        = stages[DEPTH-1];
    assign any_busy = |stages;

endmodule

// File: rtl/pe_row_feeder.sv
// Assembles a scalar element stream into lane vectors for the PE row and
// applies new weights only after in-flight data has left the row pipeline.
module pe_row_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_BW     = 8,
    parameter int WEIGHT_BW   = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int PIPE_LAT    = DEFAULT_PIPE_LAT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             s_is_weight,
    input  logic [DATA_BW-1:0]               s_data,
    output logic [DATA_BW*MATRIX_SIZE-1:0]   data_vec,
    output logic [WEIGHT_BW*MATRIX_SIZE-1:0] weights_vec,
    output logic                             weight_reload,
    output logic                             vec_valid,
    output logic                             sum_valid,
    output logic                             err_mismatch
);

    localparam int CW = cnt_width(MATRIX_SIZE);
    localparam logic [CW-1:0] LAST_LANE = CW'(MATRIX_SIZE - 1);

    feeder_state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lane;
    logic          cur_is_weight;
    logic          accept;
    logic          mismatch;
    logic          last_beat;
    logic          any_busy;
    logic [DATA_BW*MATRIX_SIZE-1:0]   dbuf, dbuf_next;
    logic [WEIGHT_BW*MATRIX_SIZE-1:0] wbuf, wbuf_next;

    // A beat of the other type mid-vector restarts assembly at lane 0.
    assign accept    = s_valid && s_ready;
    assign mismatch  = accept && (cnt != '0) && (s_is_weight != cur_is_weight);
    assign lane      = mismatch ? '0 : cnt;
    assign last_beat = (lane == LAST_LANE);

    always_comb begin
        dbuf_next = dbuf;
        wbuf_next = wbuf;
        dbuf_next[int'(lane)*DATA_BW +: DATA_BW]     = s_data;
        wbuf_next[int'(lane)*WEIGHT_BW +: WEIGHT_BW] = s_data[WEIGHT_BW-1:0];
    end

    always_comb begin
        next_state    = state;
        s_ready       = 1'b0;
        weight_reload = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (accept && s_is_weight && last_beat) begin
                    next_state = W_WAIT;
                end
            end
            W_WAIT: begin
                if (!vec_valid && !any_busy) begin
                    next_state = W_APPLY;
                end
            end
            W_APPLY: begin
                weight_reload = 1'b1;
                next_state    = FILL;
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            cnt           <= '0;
            cur_is_weight <= 1'b0;
            dbuf          <= '0;
            wbuf          <= '0;
            data_vec      <= '0;
            weights_vec   <= '0;
            vec_valid     <= 1'b0;
            err_mismatch  <= 1'b0;
        end else begin
            state        <= next_state;
            vec_valid    <= accept && !s_is_weight && last_beat;
            err_mismatch <= mismatch;
            if (accept) begin
                cnt <= last_beat ? '0 : lane + 1'b1;
                if (lane == '0) begin
                    cur_is_weight <= s_is_weight;
                end
                if (s_is_weight) begin
                    wbuf <= wbuf_next;
                end else begin
                    dbuf <= dbuf_next;
                    if (last_beat) begin
                        data_vec <= dbuf_next;
                    end
                end
            end
            // Weights reach the row only on the drain-complete edge.
            if (state == W_WAIT && next_state == W_APPLY) begin
                weights_vec <= wbuf;
            end
        end
    end

    valid_delay_line #(
        .DEPTH(PIPE_LAT)
    ) u_sum_delay (
        .clk      (clk),
        .rst      (rst),
        .d        (vec_valid),
        .q        (sum_valid),
        .any_busy (any_busy)
    );

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder: an 8-lane instance plus a 1-lane instance
// used to exercise the weight drain wait right behind a data vector.
module tb_pe_row_feeder;

    logic        clk;
    logic        rst;

    logic        s_valid, s_is_weight, s_ready;
    logic [7:0]  s_data;
    logic [63:0] data_vec, weights_vec;
    logic        weight_reload, vec_valid, sum_valid, err_mismatch;

    logic        s_valid1, s_is_weight1, s_ready1;
    logic [7:0]  s_data1;
    logic [7:0]  data_vec1, weights_vec1;
    logic        weight_reload1, vec_valid1, sum_valid1, err_mismatch1;

    int total_checks;
    int passed_checks;

    pe_row_feeder #(
        .DATA_BW(8), .WEIGHT_BW(8), .MATRIX_SIZE(8), .PIPE_LAT(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_is_weight(s_is_weight), .s_data(s_data),
        .data_vec(data_vec), .weights_vec(weights_vec), .weight_reload(weight_reload),
        .vec_valid(vec_valid), .sum_valid(sum_valid), .err_mismatch(err_mismatch)
    );

    pe_row_feeder #(
        .DATA_BW(8), .WEIGHT_BW(8), .MATRIX_SIZE(1), .PIPE_LAT(2)
    ) dut1 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_is_weight(s_is_weight1), .s_data(s_data1),
        .data_vec(data_vec1), .weights_vec(weights_vec1), .weight_reload(weight_reload1),
        .vec_valid(vec_valid1), .sum_valid(sum_valid1), .err_mismatch(err_mismatch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat for one cycle; returns 1ns into the following cycle.
    task automatic applyStimulus(input logic w, input logic [7:0] d);
        s_valid     = 1'b1;
        s_is_weight = w;
        s_data      = d;
        step();
        s_valid     = 1'b0;
    endtask

    task automatic applyStimulus1(input logic w, input logic [7:0] d);
        s_valid1     = 1'b1;
        s_is_weight1 = w;
        s_data1      = d;
        step();
        s_valid1     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int vv_count;
        int ready_drops;
        int reload_count;
        logic sv_hist [16];

        total_checks  = 0;
        passed_checks = 0;
        s_valid = 0; s_is_weight = 0; s_data = 0;
        s_valid1 = 0; s_is_weight1 = 0; s_data1 = 0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        checkOutput("rst_data_vec", data_vec, 64'h0);
        checkOutput("rst_weights_vec", weights_vec, 64'h0);
        checkOutput("rst_vec_valid", vec_valid, 1'b0);
        checkOutput("rst_sum_valid", sum_valid, 1'b0);
        checkOutput("rst_reload", weight_reload, 1'b0);
        checkOutput("rst_err", err_mismatch, 1'b0);
        checkOutput("rst_s_ready", s_ready, 1'b1);
        rst = 1'b0;
        step();

        // Data vector 1..8
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 8'(i));
            if (i == 7) checkOutput("d1_no_early_vv", vec_valid, 1'b0);
        end
        checkOutput("d1_vec_valid", vec_valid, 1'b1);
        checkOutput("d1_data_vec", data_vec, 64'h0807060504030201);
        checkOutput("d1_sum_early", sum_valid, 1'b0);
        step();
        checkOutput("d1_vv_pulse", vec_valid, 1'b0);
        checkOutput("d1_sum_t2", sum_valid, 1'b0);
        step();
        checkOutput("d1_sum_t3", sum_valid, 1'b1);
        step();
        checkOutput("d1_sum_t4", sum_valid, 1'b0);

        // Weight vector of -1 with idle pipeline
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hFF);
        checkOutput("w1_ready_t1", s_ready, 1'b0);
        checkOutput("w1_reload_t1", weight_reload, 1'b0);
        step();
        checkOutput("w1_reload_t2", weight_reload, 1'b1);
        checkOutput("w1_ready_t2", s_ready, 1'b0);
        checkOutput("w1_weights", weights_vec, 64'hFFFFFFFFFFFFFFFF);
        step();
        checkOutput("w1_reload_t3", weight_reload, 1'b0);
        checkOutput("w1_ready_t3", s_ready, 1'b1);
        checkOutput("w1_data_kept", data_vec, 64'h0807060504030201);

        // Mismatch: 3 data beats then weights
        applyStimulus(1'b0, 8'h10);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h12);
        checkOutput("mm_err_before", err_mismatch, 1'b0);
        applyStimulus(1'b1, 8'h21);
        checkOutput("mm_err_pulse", err_mismatch, 1'b1);
        vv_count = 0;
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i));
            if (i == 2) checkOutput("mm_err_once", err_mismatch, 1'b0);
            if (vec_valid) vv_count++;
        end
        checkOutput("mm_no_vv", vv_count, 0);
        checkOutput("mm_ready_wait", s_ready, 1'b0);
        step();
        checkOutput("mm_reload", weight_reload, 1'b1);
        checkOutput("mm_weights", weights_vec, 64'h2827262524232221);
        checkOutput("mm_data_kept", data_vec, 64'h0807060504030201);
        step();

        // 16 contiguous data beats 0..15
        vv_count    = 0;
        ready_drops = 0;
        for (int i = 0; i < 16; i++) begin
            if (!s_ready) ready_drops++;
            applyStimulus(1'b0, 8'(i));
            s_valid = 1'b1;
            if (vec_valid) vv_count++;
            sv_hist[i] = sum_valid;
            if (i == 7) checkOutput("b2b_vec_a", data_vec, 64'h0706050403020100);
            if (i == 15) checkOutput("b2b_vec_b", data_vec, 64'h0F0E0D0C0B0A0908);
            if (i == 8) checkOutput("b2b_vv_gap", vec_valid, 1'b0);
        end
        s_valid = 1'b0;
        checkOutput("b2b_vv_count", vv_count, 2);
        checkOutput("b2b_ready_drops", ready_drops, 0);
        checkOutput("b2b_sum_a_pre", sv_hist[8], 1'b0);
        checkOutput("b2b_sum_a", sv_hist[9], 1'b1);
        checkOutput("b2b_sum_a_post", sv_hist[10], 1'b0);
        step();
        step();
        checkOutput("b2b_sum_b", sum_valid, 1'b1);
        step();

        // Reset mid-vector
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h55);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_data", data_vec, 64'h0);
        checkOutput("rst_mid_weights", weights_vec, 64'h0);
        checkOutput("rst_mid_ready", s_ready, 1'b1);
        step();
        rst = 1'b0;
        step();

        // Reset while in W_WAIT
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h66);
        checkOutput("rst_ww_ready_before", s_ready, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_ww_ready", s_ready, 1'b1);
        checkOutput("rst_ww_reload", weight_reload, 1'b0);
        step();
        rst = 1'b0;
        reload_count = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (weight_reload) reload_count++;
        end
        checkOutput("rst_ww_no_reload", reload_count, 0);
        checkOutput("rst_ww_weights", weights_vec, 64'h0);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 8'(8'h30 + i));
        checkOutput("post_rst_vv", vec_valid, 1'b1);
        checkOutput("post_rst_data", data_vec, 64'h3837363534333231);
        step();
        step();

        // One-lane instance: weights right behind a data vector wait for drain
        applyStimulus1(1'b0, 8'h5A);
        checkOutput("m1_vec_valid", vec_valid1, 1'b1);
        checkOutput("m1_data_vec", data_vec1, 8'h5A);
        applyStimulus1(1'b1, 8'h7E);
        checkOutput("m1_ready_wait", s_ready1, 1'b0);
        checkOutput("m1_reload_t2", weight_reload1, 1'b0);
        step();
        checkOutput("m1_sum_t3", sum_valid1, 1'b1);
        checkOutput("m1_reload_t3", weight_reload1, 1'b0);
        step();
        checkOutput("m1_reload_t4", weight_reload1, 1'b0);
        checkOutput("m1_weights_held", weights_vec1, 8'h00);
        step();
        checkOutput("m1_reload_t5", weight_reload1, 1'b1);
        checkOutput("m1_sum_t5", sum_valid1, 1'b0);
        checkOutput("m1_weights", weights_vec1, 8'h7E);
        step();
        checkOutput("m1_reload_t6", weight_reload1, 1'b0);
        checkOutput("m1_ready_t6", s_ready1, 1'b1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
